frame_ram_scheduler: RTL and testbench

- Owns both ports of the palette-index frame RAM (1-cycle synchronous read, synchronous write, 5-bit data, 19-bit addresses).
- Shares the single read port between the VGA pixel fetch and a host (game-logic/loader) port; display has priority with a bounded-starvation override.
- Maps DrawX/DrawY plus a movable image origin to a linear address and flags out-of-image pixels.
- Serialises host reads and writes through a req/ack handshake.

---
 rtl/frame_ram_pkg.sv | 34 +++
 rtl/frame_addr_gen.sv | 24 ++
 rtl/frame_ram_scheduler.sv | 146 ++++++++++++++
 tb/tb_frame_ram_scheduler.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/frame_ram_pkg.sv
// Shared geometry, widths and enums for the palette-index frame RAM and
// the blocks that read it (display scheduler, sprite controllers).
package frame_ram_pkg;

  localparam int IMG_W      = 20;
  localparam int IMG_H      = 20;
  localparam int DEPTH      = IMG_W * IMG_H;
  localparam int DATA_W     = 5;
  localparam int ADDR_W     = 19;
  localparam int STARVE_MAX = 8;
  localparam int STARVE_CW  = $clog2(STARVE_MAX + 1);

  // Per-slot tag carried alongside a read-port access.
  typedef enum logic [2:0] {
    TAG_NONE,
    TAG_DISP,
    TAG_DISP_OUT,
    TAG_DISP_DROP,
    TAG_HOST
  } tag_e;

  typedef enum logic [1:0] {
    HS_IDLE,
    HS_RD_PEND,
    HS_ACK
  } host_state_e;

  // pix_tag: what the pixel result will report; owner: who drives the read port.
  typedef struct packed {
    tag_e pix_tag;
    tag_e owner;
  } rd_slot_t;

endpackage

// File: rtl/frame_addr_gen.sv
// Screen coordinate + image origin -> linear image address and in-image flag.
// Offsets wrap in 10 bits, so pixels left of / above the origin land out of range.
module frame_addr_gen
  import frame_ram_pkg::*;
(
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [9:0]        OrgX,
  input  logic [9:0]        OrgY,
  output logic [ADDR_W-1:0] addr,
  output logic              in_image
);

  logic [9:0] rx;
  logic [9:0] ry;

  always_comb begin
    rx       = DrawX - OrgX;
    ry       = DrawY - OrgY;
    in_image = (rx < 10'(IMG_W)) && (ry < 10'(IMG_H));
    addr     = ADDR_W'(ry) * ADDR_W'(IMG_W) + ADDR_W'(rx);
  end

endmodule

// File: rtl/frame_ram_scheduler.sv
// Arbitrates the frame RAM read port between pixel fetch and a host port,
// and drives the dedicated write port for host writes.
module frame_ram_scheduler
  import frame_ram_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              pix_en,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [9:0]        OrgX,
  input  logic [9:0]        OrgY,
  output logic              pix_valid,
  output logic              pix_in,
  output logic              pix_drop,
  output logic [DATA_W-1:0] pix_data,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic              host_err,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] ram_read_address,
  output logic [ADDR_W-1:0] ram_write_address,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_data_out
);

  // Host handshake: the host raises host_req with we/addr/wdata stable and holds
  // them until host_ack; host_ack is a single-cycle pulse carrying host_err and
  // host_rdata. The request is sampled only in IDLE, so req seen during the ack
  // cycle never starts a new transaction.

  logic [ADDR_W-1:0]    pix_addr;
  logic                 in_image;
  host_state_e          state_q, state_d;
  logic [STARVE_CW-1:0] starve_q;
  rd_slot_t             s1_q, s2_q, s1_d;
  logic [ADDR_W-1:0]    rd_addr_d;
  logic                 err_q;
  logic                 pix_busy, host_oob;
  logic                 grant, force_grant, wr_go, err_go, rd_wait;

  frame_addr_gen u_addr_gen (
    .DrawX    (DrawX),
    .DrawY    (DrawY),
    .OrgX     (OrgX),
    .OrgY     (OrgY),
    .addr     (pix_addr),
    .in_image (in_image)
  );

  assign pix_busy = pix_en && in_image;
  assign host_oob = host_addr >= ADDR_W'(DEPTH);

  always_comb begin
    state_d     = state_q;
    grant       = 1'b0;
    force_grant = 1'b0;
    wr_go       = 1'b0;
    err_go      = 1'b0;
    rd_wait     = 1'b0;
    case (state_q)
      HS_IDLE: begin
        if (host_req) begin
          if (host_oob) begin
            err_go  = 1'b1;
            state_d = HS_ACK;
          end else if (host_we) begin
            wr_go   = 1'b1;
            state_d = HS_ACK;
          end else if (!pix_busy || starve_q == STARVE_CW'(STARVE_MAX)) begin
            grant       = 1'b1;
            force_grant = pix_busy;
            state_d     = HS_RD_PEND;
          end else begin
            rd_wait = 1'b1;
          end
        end
      end
      HS_RD_PEND: if (s1_q.owner == TAG_HOST) state_d = HS_ACK;
      HS_ACK:     state_d = HS_IDLE;
      default:    state_d = HS_IDLE;
    endcase
  end

  // A forced host grant steals the port; the pixel is still reported, as dropped.
  always_comb begin
    s1_d      = '{pix_tag: TAG_NONE, owner: TAG_NONE};
    rd_addr_d = ram_read_address;
    if (pix_en) begin
      if (!in_image) begin
        s1_d.pix_tag = TAG_DISP_OUT;
      end else if (force_grant) begin
        s1_d.pix_tag = TAG_DISP_DROP;
      end else begin
        s1_d.pix_tag = TAG_DISP;
        s1_d.owner   = TAG_DISP;
        rd_addr_d    = pix_addr;
      end
    end
    if (grant) begin
      s1_d.owner = TAG_HOST;
      rd_addr_d  = host_addr;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q           <= HS_IDLE;
      starve_q          <= '0;
      s1_q              <= '{pix_tag: TAG_NONE, owner: TAG_NONE};
      s2_q              <= '{pix_tag: TAG_NONE, owner: TAG_NONE};
      err_q             <= 1'b0;
      ram_read_address  <= '0;
      ram_write_address <= '0;
      ram_data_in       <= '0;
      ram_we            <= 1'b0;
    end else begin
      state_q          <= state_d;
      s1_q             <= s1_d;
      s2_q             <= s1_q;
      ram_read_address <= rd_addr_d;
      ram_we           <= wr_go;
      if (state_q == HS_IDLE) err_q <= err_go;
      if (grant)        starve_q <= '0;
      else if (rd_wait) starve_q <= starve_q + 1'b1;
      if (wr_go) begin
        ram_write_address <= host_addr;
        ram_data_in       <= host_wdata;
      end
    end
  end

  // Stage-2 results pair with ram_data_out, which the RAM itself registers.
  assign pix_valid  = s2_q.pix_tag != TAG_NONE;
  assign pix_in     = s2_q.pix_tag == TAG_DISP;
  assign pix_drop   = s2_q.pix_tag == TAG_DISP_DROP;
  assign pix_data   = pix_in ? ram_data_out : '0;
  assign host_ack   = state_q == HS_ACK;
  assign host_err   = host_ack && err_q;
  assign host_rdata = (host_ack && s2_q.owner == TAG_HOST) ? ram_data_out : '0;

endmodule

// File: tb/tb_frame_ram_scheduler.sv
// Directed bench for frame_ram_scheduler with a behavioural read-before-write
// RAM preloaded so that RAM[a] = a mod 32.
module tb_frame_ram_scheduler;

  logic        Clk;
  logic        Reset_n;
  logic        pix_en;
  logic [9:0]  DrawX, DrawY, OrgX, OrgY;
  logic        pix_valid, pix_in, pix_drop;
  logic [4:0]  pix_data;
  logic        host_req, host_we;
  logic [18:0] host_addr;
  logic [4:0]  host_wdata;
  logic        host_ack, host_err;
  logic [4:0]  host_rdata;
  logic [18:0] ram_read_address, ram_write_address;
  logic [4:0]  ram_data_in;
  logic        ram_we;
  logic [4:0]  ram_data_out;

  logic [4:0]  mem [0:511];
  int          n_tests = 0;
  int          n_fail  = 0;

  frame_ram_scheduler dut (
    .Clk               (Clk),
    .Reset_n           (Reset_n),
    .pix_en            (pix_en),
    .DrawX             (DrawX),
    .DrawY             (DrawY),
    .OrgX              (OrgX),
    .OrgY              (OrgY),
    .pix_valid         (pix_valid),
    .pix_in            (pix_in),
    .pix_drop          (pix_drop),
    .pix_data          (pix_data),
    .host_req          (host_req),
    .host_we           (host_we),
    .host_addr         (host_addr),
    .host_wdata        (host_wdata),
    .host_ack          (host_ack),
    .host_err          (host_err),
    .host_rdata        (host_rdata),
    .ram_read_address  (ram_read_address),
    .ram_write_address (ram_write_address),
    .ram_data_in       (ram_data_in),
    .ram_we            (ram_we),
    .ram_data_out      (ram_data_out)
  );

  // Clock and RAM model
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 5'(i);
    ram_data_out = 5'd0;
  end

  always @(posedge Clk) begin
    ram_data_out <= mem[ram_read_address[8:0]];
    if (ram_we) mem[ram_write_address[8:0]] <= ram_data_in;
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    Reset_n    = 1'b1;
    pix_en     = 1'b0;
    DrawX      = 10'd0;
    DrawY      = 10'd0;
    OrgX       = 10'd100;
    OrgY       = 10'd50;
    host_req   = 1'b0;
    host_we    = 1'b0;
    host_addr  = 19'd0;
    host_wdata = 5'd0;
    #1 Reset_n = 1'b0;
    #3;
    check("rst_pix_valid", pix_valid, 0);
    check("rst_host_ack", host_ack, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_rd_addr", ram_read_address, 0);
    check("rst_pix_data", pix_data, 0);
    @(negedge Clk) Reset_n = 1'b1;
    tick();

    // In-image pixel at (103,52): address 43, data 11
    pix_en = 1'b1; DrawX = 10'd103; DrawY = 10'd52;
    tick();
    pix_en = 1'b0;
    check("px_rd_addr", ram_read_address, 43);
    check("px_valid_early", pix_valid, 0);
    tick();
    check("px_valid", pix_valid, 1);
    check("px_in", pix_in, 1);
    check("px_drop", pix_drop, 0);
    check("px_data", pix_data, 11);
    tick();
    check("px_valid_once", pix_valid, 0);

    // Out-of-image pixels: left (wrapped) and right edge
    pix_en = 1'b1; DrawX = 10'd99;
    tick();
    DrawX = 10'd120;
    check("out_no_read_a", ram_read_address, 43);
    tick();
    pix_en = 1'b0;
    check("out_l_valid", pix_valid, 1);
    check("out_l_in", pix_in, 0);
    check("out_l_data", pix_data, 0);
    check("out_no_read_b", ram_read_address, 43);
    tick();
    check("out_r_valid", pix_valid, 1);
    check("out_r_in", pix_in, 0);
    check("out_r_data", pix_data, 0);
    tick();
    check("out_done", pix_valid, 0);

    // Host write 0x1A to address 7, then read it back
    host_req = 1'b1; host_we = 1'b1; host_addr = 19'd7; host_wdata = 5'h1A;
    check("wr_we_idle", ram_we, 0);
    tick();
    host_req = 1'b0;
    check("wr_we", ram_we, 1);
    check("wr_waddr", ram_write_address, 7);
    check("wr_wdata", ram_data_in, 5'h1A);
    check("wr_ack", host_ack, 1);
    check("wr_err", host_err, 0);
    tick();
    check("wr_we_once", ram_we, 0);
    check("wr_ack_once", host_ack, 0);
    host_req = 1'b1; host_we = 1'b0;
    tick();
    check("rd_ack_g1", host_ack, 0);
    check("rd_addr", ram_read_address, 7);
    tick();
    host_req = 1'b0;
    check("rd_ack", host_ack, 1);
    check("rd_data", host_rdata, 5'h1A);
    check("rd_err", host_err, 0);
    tick();
    check("rd_ack_once", host_ack, 0);

    // Host read starved by continuous in-image fetch; forced on the 9th cycle
    host_req = 1'b1; host_we = 1'b0; host_addr = 19'd5;
    for (int k = 0; k < 12; k++) begin
      pix_en = (k <= 9);
      DrawX  = 10'(100 + k);
      DrawY  = 10'd52;
      if (k >= 2) begin
        check("st_valid", pix_valid, (k - 2 <= 9) ? 1 : 0);
        check("st_drop", pix_drop, (k == 10) ? 1 : 0);
        check("st_in", pix_in, (k != 10 && k - 2 <= 9) ? 1 : 0);
        check("st_data", pix_data, (k == 10 || k > 11) ? 0 : (38 + k) % 32);
      end
      check("st_ack", host_ack, (k == 10) ? 1 : 0);
      if (k == 9) check("st_host_addr", ram_read_address, 5);
      if (k == 10) begin
        check("st_rdata", host_rdata, 5);
        host_req = 1'b0;
      end
      tick();
    end
    pix_en = 1'b0;

    // Out-of-range host address: read then write
    host_req = 1'b1; host_we = 1'b0; host_addr = 19'd400;
    tick();
    host_req = 1'b0;
    check("oob_rd_ack", host_ack, 1);
    check("oob_rd_err", host_err, 1);
    check("oob_rd_data", host_rdata, 0);
    tick();
    check("oob_rd_ack_once", host_ack, 0);
    host_req = 1'b1; host_we = 1'b1; host_wdata = 5'h1F;
    tick();
    host_req = 1'b0;
    check("oob_wr_ack", host_ack, 1);
    check("oob_wr_err", host_err, 1);
    check("oob_wr_we", ram_we, 0);
    tick();
    check("oob_wr_we_after", ram_we, 0);

    // Reset while a read is pending
    host_req = 1'b1; host_we = 1'b0; host_addr = 19'd7;
    tick();
    #2 Reset_n = 1'b0;
    #1;
    check("ar_rd_addr", ram_read_address, 0);
    check("ar_ack", host_ack, 0);
    check("ar_pix_valid", pix_valid, 0);
    check("ar_we", ram_we, 0);
    @(negedge Clk);
    host_req = 1'b0;
    Reset_n  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("ar_no_ack", host_ack, 0);
    end
    host_req = 1'b1;
    tick();
    check("ar2_ack_g1", host_ack, 0);
    tick();
    host_req = 1'b0;
    check("ar2_ack", host_ack, 1);
    check("ar2_data", host_rdata, 5'h1A);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
